// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU selects, FSM states.
package alu_pkg;

  // Instruction opcodes (upper nibble of the instruction byte)
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation selects
  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_MUL = 3'b100;
  localparam logic [2:0] SEL_DIV = 3'b101;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode decoder: maps an opcode nibble to ALU controls and class flags.
module alu_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] op_select,
  output logic       sub,
  output logic       is_multicycle,
  output logic       is_ctrl
);

  // ALU opcodes get a select; everything else is a control/NOP opcode
  always_comb begin
    op_select     = SEL_ADD;
    sub           = 1'b0;
    is_multicycle = 1'b0;
    is_ctrl       = 1'b0;
    case (opcode)
      OP_ADD: op_select = SEL_ADD;
      OP_SUB: begin
        op_select = SEL_SUB;
        sub       = 1'b1;
      end
      OP_AND: op_select = SEL_AND;
      OP_OR:  op_select = SEL_OR;
      OP_MUL: begin
        op_select     = SEL_MUL;
        is_multicycle = 1'b1;
      end
      OP_DIV: begin
        op_select     = SEL_DIV;
        is_multicycle = 1'b1;
      end
      default: is_ctrl = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Top-level sequencer: fetches from program ROM, drives the ALU, owns acc/pc.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op_select,
  output logic              alu_sub,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] acc,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [7:0]        ir_reg;
  logic              start_reg;
  logic              halted_reg;
  logic              fault_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;

  logic [2:0] ir_sel;
  logic       ir_sub;
  logic       ir_mc;
  logic       ir_ctrl;
  logic [3:0] rd_op;
  logic       launch;
  logic       div_by_zero;
  logic       alu_phase;

  alu_decode u_decode (
    .opcode        (ir_reg[7:4]),
    .op_select     (ir_sel),
    .sub           (ir_sub),
    .is_multicycle (ir_mc),
    .is_ctrl       (ir_ctrl)
  );

  // The start pulse is registered, so it is decided from the ROM word while still in DECODE
  assign rd_op       = imem_rdata[7:4];
  assign launch      = (rd_op == OP_MUL) || ((rd_op == OP_DIV) && (imem_rdata[3:0] != 4'h0));
  assign div_by_zero = (ir_reg[7:4] == OP_DIV) && (ir_reg[3:0] == 4'h0);
  assign alu_phase   = (state_reg == ST_EXEC) || (state_reg == ST_WAIT);

  assign imem_addr     = pc_reg;
  assign pc            = pc_reg;
  assign acc           = acc_reg;
  assign alu_a         = acc_reg;
  assign alu_b         = DATA_W'(ir_reg[3:0]);
  assign alu_op_select = alu_phase ? ir_sel : 3'b000;
  assign alu_sub       = alu_phase ? ir_sub : 1'b0;
  assign alu_start     = start_reg;
  assign halted        = halted_reg;
  assign fault         = fault_reg;

  // Sequencer FSM with all architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= '0;
      acc_reg      <= '0;
      ir_reg       <= '0;
      start_reg    <= 1'b0;
      halted_reg   <= 1'b0;
      fault_reg    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (run) state_reg <= ST_FETCH;
        end
        ST_FETCH: state_reg <= ST_DECODE;
        ST_DECODE: begin
          ir_reg    <= imem_rdata;
          start_reg <= launch;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          state_reg <= ST_FETCH;
          if (!ir_ctrl) begin
            if (!ir_mc) begin
              acc_reg <= alu_result;
              pc_reg  <= pc_reg + PC_W'(1);
            end else if (div_by_zero) begin
              acc_reg <= '1;
              pc_reg  <= pc_reg + PC_W'(1);
            end else begin
              wait_cnt_reg <= '0;
              state_reg    <= ST_WAIT;
            end
          end else begin
            case (ir_reg[7:4])
              OP_LDI: begin
                acc_reg <= DATA_W'(ir_reg[3:0]);
                pc_reg  <= pc_reg + PC_W'(1);
              end
              OP_JMP: pc_reg <= PC_W'(ir_reg[3:0]);
              OP_JZ: begin
                if (acc_reg == '0) pc_reg <= PC_W'(ir_reg[3:0]);
                else               pc_reg <= pc_reg + PC_W'(1);
              end
              OP_HLT: begin
                halted_reg <= 1'b1;
                state_reg  <= ST_HALT;
              end
              default: pc_reg <= pc_reg + PC_W'(1);
            endcase
          end
        end
        ST_WAIT: begin
          if (alu_done) begin
            acc_reg   <= alu_result;
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= ST_FETCH;
          end else if (wait_cnt_reg == CNT_W'(MAX_WAIT - 1)) begin
            fault_reg  <= 1'b1;
            halted_reg <= 1'b1;
            state_reg  <= ST_HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, directed corner cases, random programs.
module tb_alu_sequencer;

  localparam int DATA_W   = 8;
  localparam int PC_W     = 4;
  localparam int MAX_WAIT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [PC_W-1:0]   imem_addr;
  logic [7:0]        imem_rdata;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result, acc;
  logic [2:0]        alu_op_select;
  logic              alu_sub, alu_start, alu_done, halted, fault;
  logic [PC_W-1:0]   pc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // ROM, ALU-latency and fault-injection controls
  logic [7:0] rom [16];
  int         lat;
  logic       never;
  logic       spur;
  logic       alu_clr;
  int         cnt;
  logic       done_q;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(DATA_W), .PC_W(PC_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_select(alu_op_select), .alu_sub(alu_sub),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .acc(acc), .pc(pc), .halted(halted), .fault(fault)
  );

  // Synchronous program ROM
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  // ALU datapath stand-in
  always_comb begin
    alu_result = '0;
    case (alu_op_select)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a * alu_b;
      3'd5: alu_result = (alu_b != 0) ? (alu_a / alu_b) : '1;
      default: alu_result = '0;
    endcase
  end

  // Multi-cycle handshake: done pulses lat cycles after the start cycle
  always @(posedge clk) begin
    if (alu_clr) begin
      cnt    <= 0;
      done_q <= 1'b0;
    end else if (alu_start) begin
      cnt    <= never ? 0 : lat - 1;
      done_q <= !never && (lat == 1);
    end else if (cnt != 0) begin
      cnt    <= cnt - 1;
      done_q <= (cnt == 1);
    end else begin
      done_q <= 1'b0;
    end
  end
  assign alu_done = done_q | spur;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  // Reset, then launch execution; returns in the first FETCH cycle
  task automatic load_and_start();
    reset = 1'b1; run = 1'b0; alu_clr = 1'b1; spur = 1'b0;
    step(); step();
    reset = 1'b0; alu_clr = 1'b0; run = 1'b1;
    step();
    run = 1'b0;
  endtask

  // Clock through one instruction, counting start pulses and capturing EXEC controls
  task automatic exec_instr(input int dur, output int starts, output logic [2:0] sel, output logic sb);
    starts = 0; sel = 3'b0; sb = 1'b0;
    for (int k = 0; k < dur; k++) begin
      if (k == 2) begin
        sel = alu_op_select;
        sb  = alu_sub;
      end
      if (alu_start) starts++;
      step();
    end
  endtask

  // Instruction-level reference: architectural effect and cycle cost of one instruction
  function automatic void model(input logic [7:0] ins, input int l,
                                inout logic [7:0] m_acc, inout logic [3:0] m_pc,
                                output logic m_halt, output int dur, output int starts);
    int op, imm, a;
    op = int'(ins[7:4]); imm = int'(ins[3:0]); a = int'(m_acc);
    dur = 3; starts = 0; m_halt = 1'b0;
    case (op)
      0: a = a + imm;
      1: a = a - imm + 256;
      2: a = a & imm;
      3: a = a | imm;
      4: begin a = a * imm; dur = 3 + l; starts = 1; end
      5: if (imm == 0) a = 255; else begin a = a / imm; dur = 3 + l; starts = 1; end
      6: a = imm;
      default: ;
    endcase
    m_acc = 8'(a % 256);
    if (op == 7) m_pc = 4'(imm);
    else if (op == 8) m_pc = (m_acc == 0) ? 4'(imm) : 4'((int'(m_pc) + 1) % 16);
    else if (op == 15) m_halt = 1'b1;
    else m_pc = 4'((int'(m_pc) + 1) % 16);
  endfunction

  typedef struct {
    logic [3:0] ldi;
    logic [7:0] ins;
    int         dur;
    logic [7:0] e_acc;
    logic [3:0] e_pc;
    logic       chk_sel;
    logic [2:0] e_sel;
    logic       e_sub;
    int         e_starts;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int st, n;
    logic [2:0] sel;
    logic sb;
    logic [7:0] m_acc;
    logic [3:0] m_pc;
    logic m_halt;
    int dur, es;

    reset = 1'b1; run = 1'b0; spur = 1'b0; alu_clr = 1'b1; lat = 3; never = 1'b0;
    fill_rom(8'hF0);

    // Reset state
    step(); step();
    chk("rst_acc", acc, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_start", alu_start, 0);

    // IDLE holds without run, then LDI 5 / ADD 3 / HLT
    rom[0] = 8'h65; rom[1] = 8'h03; rom[2] = 8'hF0;
    reset = 1'b0; alu_clr = 1'b0;
    step(); step(); step();
    chk("idle_pc", pc, 0);
    chk("idle_halted", halted, 0);
    run = 1'b1; step(); run = 1'b0;
    exec_instr(3, st, sel, sb);
    chk("ldi5_acc", acc, 8'h05);
    exec_instr(3, st, sel, sb);
    chk("add3_acc", acc, 8'h08);
    n = 0;
    while (!halted && n < 20) begin step(); n++; end
    chk("halt_latency", 6 + n, 9);
    chk("halt_pc", pc, 2);
    run = 1'b1; step(); step(); step(); run = 1'b0;
    chk("halt_sticky", halted, 1);
    chk("halt_pc_hold", pc, 2);
    $display("basic: acc=%02h pc=%0d halted=%0b", acc, pc, halted);

    // Table of single-instruction vectors, each preceded by LDI
    vecs[0]  = '{4'h9, 8'h14, 3, 8'h05, 4'h2, 1'b1, 3'd1, 1'b1, 0};
    vecs[1]  = '{4'h5, 8'h03, 3, 8'h08, 4'h2, 1'b1, 3'd0, 1'b0, 0};
    vecs[2]  = '{4'hC, 8'h26, 3, 8'h04, 4'h2, 1'b1, 3'd2, 1'b0, 0};
    vecs[3]  = '{4'h9, 8'h36, 3, 8'h0F, 4'h2, 1'b1, 3'd3, 1'b0, 0};
    vecs[4]  = '{4'h3, 8'h44, 6, 8'h0C, 4'h2, 1'b1, 3'd4, 1'b0, 1};
    vecs[5]  = '{4'hD, 8'h53, 6, 8'h04, 4'h2, 1'b1, 3'd5, 1'b0, 1};
    vecs[6]  = '{4'h7, 8'h50, 3, 8'hFF, 4'h2, 1'b1, 3'd5, 1'b0, 0};
    vecs[7]  = '{4'h0, 8'h85, 3, 8'h00, 4'h5, 1'b0, 3'd0, 1'b0, 0};
    vecs[8]  = '{4'h1, 8'h85, 3, 8'h01, 4'h2, 1'b0, 3'd0, 1'b0, 0};
    vecs[9]  = '{4'h4, 8'h7A, 3, 8'h04, 4'hA, 1'b0, 3'd0, 1'b0, 0};
    vecs[10] = '{4'h4, 8'h93, 3, 8'h04, 4'h2, 1'b0, 3'd0, 1'b0, 0};
    vecs[11] = '{4'h2, 8'h6E, 3, 8'h0E, 4'h2, 1'b0, 3'd0, 1'b0, 0};
    vecs[12] = '{4'h0, 8'h13, 3, 8'hFD, 4'h2, 1'b1, 3'd1, 1'b1, 0};
    lat = 3; never = 1'b0;
    for (int v = 0; v < 13; v++) begin
      fill_rom(8'hF0);
      rom[0] = {4'h6, vecs[v].ldi};
      rom[1] = vecs[v].ins;
      load_and_start();
      exec_instr(3, st, sel, sb);
      exec_instr(vecs[v].dur, st, sel, sb);
      chk($sformatf("vec%0d_acc", v), acc, vecs[v].e_acc);
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].e_pc);
      chk($sformatf("vec%0d_starts", v), st, vecs[v].e_starts);
      chk($sformatf("vec%0d_halted", v), halted, 0);
      if (vecs[v].chk_sel) begin
        chk($sformatf("vec%0d_sel", v), sel, vecs[v].e_sel);
        chk($sformatf("vec%0d_sub", v), sb, vecs[v].e_sub);
      end
      $display("vec %0d: ins=%02h acc=%02h pc=%0d sel=%0d sub=%0b starts=%0d",
               v, vecs[v].ins, acc, pc, sel, sb, st);
    end

    // MUL handshake with latency 5 and spurious done in FETCH and EXEC
    fill_rom(8'hF0);
    rom[0] = 8'h63; rom[1] = 8'h44;
    lat = 5; never = 1'b0;
    load_and_start();
    exec_instr(3, st, sel, sb);
    spur = 1'b1; step(); spur = 1'b0;
    step();
    chk("mul_start_exec", alu_start, 1);
    n = 1;
    spur = 1'b1; step(); spur = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (alu_start) n++;
      chk("mul_acc_waiting", acc, 8'h03);
      step();
    end
    chk("mul_done_cycle", alu_done, 1);
    chk("mul_acc_before", acc, 8'h03);
    step();
    chk("mul_acc", acc, 8'h0C);
    chk("mul_pc", pc, 2);
    chk("mul_start_count", n, 1);
    $display("mul: acc=%02h pc=%0d starts=%0d", acc, pc, n);

    // WAIT timeout
    fill_rom(8'hF0);
    rom[0] = 8'h44;
    never = 1'b1;
    load_and_start();
    step(); step(); step();
    for (int k = 0; k < MAX_WAIT - 1; k++) step();
    chk("tmo_not_yet_halted", halted, 0);
    chk("tmo_not_yet_fault", fault, 0);
    step();
    chk("tmo_halted", halted, 1);
    chk("tmo_fault", fault, 1);
    chk("tmo_acc", acc, 0);
    chk("tmo_pc", pc, 0);
    step(); step(); step();
    chk("tmo_fault_sticky", fault, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("tmo_fault_cleared", fault, 0);
    chk("tmo_halted_cleared", halted, 0);
    never = 1'b0;
    $display("timeout: fault cleared by reset");

    // JZ to 15, NOP at 15 wraps to 0
    fill_rom(8'hF0);
    rom[0] = 8'h60; rom[1] = 8'h8F; rom[15] = 8'h90;
    load_and_start();
    exec_instr(3, st, sel, sb);
    exec_instr(3, st, sel, sb);
    chk("jz15_pc", pc, 15);
    exec_instr(3, st, sel, sb);
    chk("wrap_pc", pc, 0);
    $display("wrap: pc=%0d", pc);

    // JMP 2 loop: LDI 1, NOP, ADD 1, JMP 2
    fill_rom(8'hF0);
    rom[0] = 8'h61; rom[1] = 8'h90; rom[2] = 8'h01; rom[3] = 8'h72;
    load_and_start();
    for (int k = 0; k < 3; k++) exec_instr(3, st, sel, sb);
    chk("loop_acc0", acc, 2);
    for (int it = 0; it < 2; it++) begin
      exec_instr(3, st, sel, sb);
      chk("loop_jmp_pc", pc, 2);
      exec_instr(3, st, sel, sb);
      chk("loop_acc", acc, 8'(3 + it));
      chk("loop_pc", pc, 3);
    end
    $display("loop: acc=%02h pc=%0d", acc, pc);

    // Reset during WAIT; the late done must not touch acc
    fill_rom(8'hF0);
    rom[0] = 8'h63; rom[1] = 8'h44;
    lat = 5;
    load_and_start();
    exec_instr(3, st, sel, sb);
    step(); step(); step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rwait_pc", pc, 0);
    chk("rwait_acc", acc, 0);
    chk("rwait_fault", fault, 0);
    chk("rwait_halted", halted, 0);
    chk("rwait_sel", alu_op_select, 0);
    for (int k = 0; k < 6; k++) step();
    chk("rwait_late_acc", acc, 0);
    chk("rwait_late_pc", pc, 0);
    $display("reset-in-wait: acc=%02h pc=%0d", acc, pc);

    // Random programs against the instruction-level model
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      lat = $urandom_range(1, 8);
      m_acc = 8'h00; m_pc = 4'h0; m_halt = 1'b0;
      load_and_start();
      n = 0;
      for (int i = 0; i < 20 && !m_halt; i++) begin
        model(rom[m_pc], lat, m_acc, m_pc, m_halt, dur, es);
        exec_instr(dur, st, sel, sb);
        chk("rnd_acc", acc, m_acc);
        chk("rnd_pc", pc, m_pc);
        chk("rnd_halted", halted, m_halt);
        chk("rnd_starts", st, es);
        n++;
      end
      chk("rnd_fault", fault, 0);
      $display("random %0d: lat=%0d instrs=%0d acc=%02h pc=%0d halted=%0b", t, lat, n, acc, pc, halted);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM that fetches 8-bit instructions from a synchronous program ROM.
- Decodes the upper nibble as the opcode and the lower nibble as a 4-bit immediate.
- Drives the ALU's op_select/sub inputs, handshakes multi-cycle MULTIPLY/DIVIDE, and writes results into an accumulator.
- Sits between program memory and the ALU datapath; it is the top-level sequencer of the simple CPU.

Parameters:
DATA_W, 8, accumulator/ALU operand width (>= 4)
PC_W, 4, program counter width; ROM depth = 2**PC_W
MAX_WAIT, 16, maximum cycles spent in WAIT for alu_done before faulting

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; sampled in IDLE, starts execution at PC=0
imem_addr  out  PC_W  ROM address; equals pc
imem_rdata  in  8  ROM data, valid one cycle after imem_addr
alu_a  out  DATA_W  operand A = acc
alu_b  out  DATA_W  operand B = zero-extended immediate
alu_op_select  out  3  ALU operation select
alu_sub  out  1  ALU subtract control
alu_start  out  1  one-cycle pulse launching MULTIPLY/DIVIDE
alu_done  in  1  multi-cycle result valid (single-cycle pulse)
alu_result  in  DATA_W  ALU result
acc  out  DATA_W  accumulator
pc  out  PC_W  program counter
halted  out  1  high in HALT state
fault  out  1  sticky: WAIT timeout occurred; cleared only by reset

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, pc=0, acc=0, ir=0, alu_start=0, halted=0, fault=0, wait counter=0.
- Reset mid-operation aborts everything, including WAIT. A later alu_done is ignored unless the FSM is in WAIT.
- States: IDLE, FETCH, DECODE, EXEC, WAIT, HALT.
- IDLE: leave to FETCH when run=1; otherwise hold.
- FETCH: imem_addr=pc; next state DECODE.
- DECODE: ir <= imem_rdata; next state EXEC.
- EXEC: decode ir[7:4].
- ALU opcode mapping (alu_op_select, alu_sub are combinational from ir in EXEC/WAIT; 0 elsewhere):
  - 0 ADD -> op_select=000, sub=0
  - 1 SUB -> op_select=001, sub=1
  - 2 AND -> op_select=010, sub=0
  - 3 OR -> op_select=011, sub=0
  - 4 MUL -> op_select=100, sub=0
  - 5 DIV -> op_select=101, sub=0
- Single-cycle ops (0-3): acc <= alu_result at the end of EXEC; pc <= pc+1; next state FETCH. Total 3 cycles per instruction.
- MUL/DIV (4-5):
  - alu_start=1 for exactly the EXEC cycle; next state WAIT.
  - In WAIT, when alu_done=1: acc <= alu_result, pc <= pc+1, next state FETCH.
  - alu_done in the EXEC cycle itself is ignored.
- DIV with imm=0: no alu_start; acc <= all-ones; pc <= pc+1; next state FETCH.
- Control opcodes:
  - 6 LDI: acc <= zero-extended imm; pc <= pc+1.
  - 7 JMP: pc <= imm, zero-extended or truncated to PC_W.
  - 8 JZ: if acc==0 then pc <= imm, else pc <= pc+1.
  - F HLT: next state HALT; pc unchanged.
  - 9-E NOP: pc <= pc+1.
- WAIT timeout: counter increments each WAIT cycle. If it reaches MAX_WAIT without alu_done: fault <= 1, next state HALT, acc unchanged. The counter clears on entering WAIT.
- HALT: halted=1; stays until reset. run is ignored.
- Arithmetic:
  - pc+1 wraps modulo 2**PC_W (last address -> 0).
  - alu_b = {DATA_W-4 zeros, imm}.
  - alu_result bits are taken as-is; no flags other than acc==0 are used.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_HLT (4-bit)
  - ALU select localparams SEL_ADD..SEL_DIV (3-bit)
  - FSM state encoding
- Natural sub-module: alu_decode, the combinational ir[7:4] -> {op_select, sub, is_multicycle, is_ctrl} decoder. The FSM and registers stay in alu_sequencer.

Test Plan:
- Reset, then run=1 with ROM {LDI 5, ADD 3, HLT}, ALU model = real adder: acc 5 then 8, halted=1 at cycle 9 after run, pc=2.
- SUB and decode: ROM {LDI 9, SUB 4}: during the SUB EXEC, op_select=001 and sub=1; acc=5 afterwards. The other ALU opcodes drive op_select 000/010/011.
- MUL handshake: ROM {LDI 3, MUL 4}; ALU model asserts alu_done 5 cycles after alu_start.
  - Exactly one alu_start pulse.
  - acc=12 in the cycle after alu_done.
  - A spurious alu_done while in FETCH is ignored.
- Timeout and divide-by-zero:
  - MUL with alu_done never asserted: fault=1 and halted=1 after MAX_WAIT WAIT cycles.
  - Separate run with DIV 0: acc=0xFF, no alu_start.
- Control flow and wrap:
  - ROM {LDI 0, JZ 5, ...} branches to pc=5.
  - NOP at address 15 wraps pc to 0.
  - JMP 2 loops correctly.
- Reset mid-WAIT: assert reset during WAIT -> state IDLE, pc=0, acc=0, fault=0 next cycle; a late alu_done does not alter acc.
